// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: FSM state enum, default pipeline geometry and the flush-mask helper shared by the stall/flush controller
package pipe_ctrl_pkg;
  typedef enum logic [2:0] {RUN, STALL, FLUSH, DRAIN, HALT} state_t;
  localparam int DEF_NUM_STAGES = 5;
  localparam int DEF_HAZARD_STAGE = 2;
  localparam int DEF_FLUSH_DEPTH = 3;
  function automatic logic [31:0] flush_mask(input int depth);
    return ((32'd1 << depth) - 32'd1) << 1;
  endfunction
endpackage

// File: rtl/pipe_valid_tracker.sv
// pipe_valid_tracker: per-stage valid shift register; ports clk, rst, in_bit (new stage-0 valid), hold/clear masks per stage, valid (registered)
module pipe_valid_tracker #(
  parameter int N = 5
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_bit,
  input  logic [N-1:0] hold,
  input  logic [N-1:0] clear,
  output logic [N-1:0] valid
);
  always_ff @(posedge clk)
    if (rst) valid <= '0;
    else valid <= ~clear & ((hold & valid) | (~hold & {valid[N-2:0], in_bit}));
endmodule

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: pipeline stall/flush/drain controller; in: clk, reset, is_hazard, hazard_len, is_branch_fault, pc_out; out: is_load_PC, stage_load, nop_step, stage_valid, halted (+ stall_cycles, flush_cycles when PIPE_PERF_CNT_EN is defined)
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int INSTRACTION_NUMBERS = 16,
  parameter int NUM_STAGES = DEF_NUM_STAGES,
  parameter int HAZARD_STAGE = DEF_HAZARD_STAGE,
  parameter int FLUSH_DEPTH = DEF_FLUSH_DEPTH,
  parameter int BRANCH_PENALTY = 1,
  parameter int CNT_W = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  is_hazard,
  input  logic [CNT_W-1:0]      hazard_len,
  input  logic                  is_branch_fault,
  input  logic [WIDTH-1:0]      pc_out,
  output logic                  is_load_PC,
  output logic [NUM_STAGES-1:0] stage_load,
  output logic [NUM_STAGES-1:0] nop_step,
  output logic [NUM_STAGES-1:0] stage_valid,
`ifdef PIPE_PERF_CNT_EN
  output logic [31:0]           stall_cycles,
  output logic [31:0]           flush_cycles,
`endif
  output logic                  halted
);
  localparam logic [NUM_STAGES-1:0] ONES = '1;
  localparam logic [NUM_STAGES-1:0] FMASK = NUM_STAGES'(flush_mask(FLUSH_DEPTH));
  localparam logic [NUM_STAGES-1:0] HBIT = NUM_STAGES'(1) << HAZARD_STAGE;
  localparam logic [NUM_STAGES-1:0] HLOAD = ONES << HAZARD_STAGE;
  localparam logic [NUM_STAGES-1:0] F1 = NUM_STAGES'(2);
  localparam logic [WIDTH-1:0] N_INSTR = WIDTH'(INSTRACTION_NUMBERS);
  localparam logic [3:0] BP = 4'(BRANCH_PENALTY);
  state_t state;
  logic [CNT_W-1:0] stall_cnt;
  logic [3:0] flush_cnt;
  logic fault, stall, eop;
  assign fault = is_branch_fault && state != HALT;
  assign eop = pc_out >= N_INSTR;
  assign stall = !fault && (state == STALL || (state == RUN && is_hazard));
  assign is_load_PC = !reset && (fault || (((state == RUN && !stall) || state == FLUSH) && !eop));
  assign stage_load = (reset || state == HALT) ? '0 : stall ? HLOAD : ONES;
  assign nop_step = reset ? ~NUM_STAGES'(1) : fault ? FMASK : stall ? HBIT : state == FLUSH ? F1 : '0;
  assign halted = !reset && state == HALT;
  // a held stage keeps its valid bit, a bubbled stage is cleared, the rest shift up
  pipe_valid_tracker #(.N(NUM_STAGES)) u_valid (
    .clk(clk),
    .rst(reset),
    .in_bit(is_load_PC),
    .hold(~stage_load),
    .clear(nop_step),
    .valid(stage_valid)
  );
  always_ff @(posedge clk)
    if (reset) begin
      state <= RUN;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else if (fault) begin
      stall_cnt <= '0;
      flush_cnt <= BP;
      state <= BP != 4'd0 ? FLUSH : RUN;
    end else
      case (state)
        RUN:
          if (is_hazard) begin
            if (hazard_len > CNT_W'(1)) begin
              state <= STALL;
              stall_cnt <= hazard_len - CNT_W'(1);
            end
          end else if (eop) state <= DRAIN;
        STALL: begin
          stall_cnt <= stall_cnt - CNT_W'(1);
          if (stall_cnt <= CNT_W'(1)) state <= RUN;
        end
        FLUSH: begin
          flush_cnt <= flush_cnt - 4'd1;
          if (flush_cnt <= 4'd1) state <= RUN;
        end
        DRAIN: if (stage_valid == '0) state <= HALT;
        default: state <= state;
      endcase
`ifdef PIPE_PERF_CNT_EN
  always_ff @(posedge clk)
    if (reset) begin
      stall_cycles <= '0;
      flush_cycles <= '0;
    end else begin
      if (stall && stall_cycles != '1) stall_cycles <= stall_cycles + 32'd1;
      if ((fault || state == FLUSH) && flush_cycles != '1) flush_cycles <= flush_cycles + 32'd1;
    end
`endif
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: directed table plus randomized run checked against a behavioural model of the stall/flush controller
module tb_pipe_hazard_ctrl;
  localparam int NS = 5, HS = 2, FD = 3, BP = 1, NI = 16;
  logic clk = 0, reset = 1, is_hazard = 0, is_branch_fault = 0;
  logic [3:0] hazard_len = 0;
  logic [31:0] pc_out = 0;
  logic is_load_PC, halted;
  logic [NS-1:0] stage_load, nop_step, stage_valid;
`ifdef PIPE_PERF_CNT_EN
  logic [31:0] stall_cycles, flush_cycles;
`endif
  int checks = 0, errors = 0;
  pipe_hazard_ctrl dut (
    .clk(clk), .reset(reset), .is_hazard(is_hazard), .hazard_len(hazard_len),
    .is_branch_fault(is_branch_fault), .pc_out(pc_out), .is_load_PC(is_load_PC),
    .stage_load(stage_load), .nop_step(nop_step), .stage_valid(stage_valid),
`ifdef PIPE_PERF_CNT_EN
    .stall_cycles(stall_cycles), .flush_cycles(flush_cycles),
`endif
    .halted(halted)
  );
  always #5 clk = ~clk;
  typedef struct {
    bit r, h, f;
    logic [3:0] len;
    int pc;
    bit e_lpc;
    logic [NS-1:0] e_load, e_nop, e_valid;
    bit e_halt;
  } vec_t;
  vec_t tv[$];
  logic [NS-1:0] m_valid = '0;
  int m_stall = 0, m_flush = 0, m_sc = 0, m_fc = 0;
  bit m_drain = 0, m_halt = 0;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask
  function automatic vec_t mk(bit r, bit h, bit f, int len, int pc, bit lpc, logic [NS-1:0] ld, logic [NS-1:0] nop, logic [NS-1:0] v, bit hl);
    vec_t t;
    t.r = r; t.h = h; t.f = f; t.len = 4'(len); t.pc = pc;
    t.e_lpc = lpc; t.e_load = ld; t.e_nop = nop; t.e_valid = v; t.e_halt = hl;
    return t;
  endfunction
  // one cycle: drive, compare against the model (and the table row if given), then let the edge happen
  task automatic step(input bit r, input bit h, input bit f, input logic [3:0] len, input int pc, input bit use_t, input vec_t t);
    bit lpc, hl, eop;
    logic [NS-1:0] ld, nop, nv;
    int kind;
    reset = r; is_hazard = h; is_branch_fault = f; hazard_len = len; pc_out = 32'(pc);
    #4;
    eop = pc >= NI;
    lpc = 0; hl = 0; ld = '1; nop = '0;
    if (r) begin kind = 0; ld = '0; nop = '1; nop[0] = 0; end
    else if (m_halt) begin kind = 1; ld = '0; hl = 1; end
    else if (f) begin kind = 2; lpc = 1; for (int i = 1; i <= FD; i++) nop[i] = 1; end
    else if (m_stall > 0 || (!m_drain && m_flush == 0 && h)) begin
      kind = 3; for (int i = 0; i < HS; i++) ld[i] = 0; nop[HS] = 1;
    end
    else if (m_flush > 0) begin kind = 4; lpc = !eop; nop[1] = 1; end
    else if (m_drain) kind = 5;
    else begin kind = 6; lpc = !eop; end
    check("model", {is_load_PC, stage_load, nop_step, stage_valid, halted}, 32'({lpc, ld, nop, m_valid, hl}));
`ifdef PIPE_PERF_CNT_EN
    check("stall_cycles", stall_cycles, 32'(m_sc));
    check("flush_cycles", flush_cycles, 32'(m_fc));
`endif
    if (use_t) check("table", {is_load_PC, stage_load, nop_step, stage_valid, halted}, 32'({t.e_lpc, t.e_load, t.e_nop, t.e_valid, t.e_halt}));
    for (int i = 0; i < NS; i++)
      if (nop[i]) nv[i] = 0;
      else if (!ld[i]) nv[i] = m_valid[i];
      else if (i == 0) nv[i] = lpc;
      else nv[i] = m_valid[i-1];
    case (kind)
      0: begin nv = '0; m_stall = 0; m_flush = 0; m_drain = 0; m_halt = 0; m_sc = 0; m_fc = 0; end
      1: nv = m_valid;
      2: begin m_stall = 0; m_flush = BP; m_drain = 0; m_fc++; end
      3: begin m_sc++; if (m_stall > 0) m_stall--; else m_stall = (len > 1 ? int'(len) : 1) - 1; end
      4: begin m_fc++; m_flush--; end
      5: if (m_valid == '0) m_halt = 1;
      default: if (eop) m_drain = 1;
    endcase
    m_valid = nv;
    @(posedge clk); #1;
  endtask
  initial begin
    vec_t z;
    z = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tv.push_back(mk(1,0,0,0, 0, 0,5'b00000,5'b11110,5'b00000,0));
    tv.push_back(mk(0,0,0,0, 0, 1,5'b11111,5'b00000,5'b00000,0));
    tv.push_back(mk(0,0,0,0, 1, 1,5'b11111,5'b00000,5'b00001,0));
    tv.push_back(mk(0,0,0,0, 2, 1,5'b11111,5'b00000,5'b00011,0));
    tv.push_back(mk(0,0,0,0, 3, 1,5'b11111,5'b00000,5'b00111,0));
    tv.push_back(mk(0,1,0,3, 4, 0,5'b11100,5'b00100,5'b01111,0));
    tv.push_back(mk(0,0,0,0, 4, 0,5'b11100,5'b00100,5'b11011,0));
    tv.push_back(mk(0,0,0,0, 4, 0,5'b11100,5'b00100,5'b10011,0));
    tv.push_back(mk(0,0,0,0, 4, 1,5'b11111,5'b00000,5'b00011,0));
    tv.push_back(mk(0,1,0,4, 5, 0,5'b11100,5'b00100,5'b00111,0));
    tv.push_back(mk(0,0,0,0, 5, 0,5'b11100,5'b00100,5'b01011,0));
    tv.push_back(mk(0,0,1,0, 5, 1,5'b11111,5'b01110,5'b10011,0));
    tv.push_back(mk(0,0,0,0, 5, 1,5'b11111,5'b00010,5'b00001,0));
    tv.push_back(mk(0,0,0,0, 6, 1,5'b11111,5'b00000,5'b00001,0));
    tv.push_back(mk(0,1,1,5, 7, 1,5'b11111,5'b01110,5'b00011,0));
    tv.push_back(mk(0,0,0,0, 7, 1,5'b11111,5'b00010,5'b00001,0));
    tv.push_back(mk(0,0,0,0, 8, 1,5'b11111,5'b00000,5'b00001,0));
    tv.push_back(mk(0,0,0,0, 9, 1,5'b11111,5'b00000,5'b00011,0));
    tv.push_back(mk(0,0,0,0,10, 1,5'b11111,5'b00000,5'b00111,0));
    tv.push_back(mk(0,0,0,0,11, 1,5'b11111,5'b00000,5'b01111,0));
    tv.push_back(mk(0,0,0,0,16, 0,5'b11111,5'b00000,5'b11111,0));
    tv.push_back(mk(0,0,0,0,16, 0,5'b11111,5'b00000,5'b11110,0));
    tv.push_back(mk(0,0,0,0,16, 0,5'b11111,5'b00000,5'b11100,0));
    tv.push_back(mk(0,0,0,0,16, 0,5'b11111,5'b00000,5'b11000,0));
    tv.push_back(mk(0,0,0,0,16, 0,5'b11111,5'b00000,5'b10000,0));
    tv.push_back(mk(0,0,0,0,16, 0,5'b11111,5'b00000,5'b00000,0));
    tv.push_back(mk(0,0,0,0,16, 0,5'b00000,5'b00000,5'b00000,1));
    tv.push_back(mk(0,1,1,3, 0, 0,5'b00000,5'b00000,5'b00000,1));
    tv.push_back(mk(0,0,1,0, 3, 0,5'b00000,5'b00000,5'b00000,1));
    tv.push_back(mk(1,0,0,0, 0, 0,5'b00000,5'b11110,5'b00000,0));
    tv.push_back(mk(0,0,0,0, 0, 1,5'b11111,5'b00000,5'b00000,0));
    tv.push_back(mk(0,1,0,4, 1, 0,5'b11100,5'b00100,5'b00001,0));
    tv.push_back(mk(1,0,0,0, 1, 0,5'b00000,5'b11110,5'b00001,0));
    tv.push_back(mk(0,0,0,0, 2, 1,5'b11111,5'b00000,5'b00000,0));
    tv.push_back(mk(0,1,0,0, 3, 0,5'b11100,5'b00100,5'b00001,0));
    tv.push_back(mk(0,0,0,0, 3, 1,5'b11111,5'b00000,5'b00001,0));
    tv.push_back(mk(0,1,0,2,16, 0,5'b11100,5'b00100,5'b00011,0));
    tv.push_back(mk(0,0,0,0,16, 0,5'b11100,5'b00100,5'b00011,0));
    tv.push_back(mk(0,0,0,0,16, 0,5'b11111,5'b00000,5'b00011,0));
    repeat (2) @(posedge clk);
    #1;
    foreach (tv[k]) step(tv[k].r, tv[k].h, tv[k].f, tv[k].len, tv[k].pc, 1, tv[k]);
    step(1, 0, 0, 0, 0, 0, z);
    for (int n = 0; n < 3000; n++)
      step($urandom_range(39) == 0, $urandom_range(5) == 0, $urandom_range(11) == 0,
           4'($urandom_range(4)), $urandom_range(19) < 18 ? int'($urandom_range(15)) : 16 + int'($urandom_range(3)), 0, z);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
Parametrised pipeline stall/flush controller for the in-order CPU pipeline.
- Generalises single-cycle nop insertion to NUM_STAGES stages, multi-cycle hazard stalls, a configurable branch-fault flush depth and penalty, and end-of-program drain/halt.
- Tracks per-stage valid bits.
- Drives PC load, per-stage register load enables and per-stage nop (bubble) injects.
- Sits between hazard detection/branch resolution and the stage pipeline registers.

Parameters:
WIDTH, 32, PC width
INSTRACTION_NUMBERS, 16, program length; fetch is stopped once pc_out >= this
NUM_STAGES, 5, pipeline stages; index 0 = fetch
HAZARD_STAGE, 2, stage that receives the bubble on a hazard; 1..NUM_STAGES-1
FLUSH_DEPTH, 3, stages 1..FLUSH_DEPTH squashed on branch fault; <= NUM_STAGES-1
BRANCH_PENALTY, 1, extra FLUSH cycles after the fault cycle; 0..15
CNT_W, 4, width of hazard_len

Ports:
clk  in  1  clock; all state updates on the rising edge
reset  in  1  synchronous, active-high reset
is_hazard  in  1  data hazard detected this cycle
hazard_len  in  CNT_W  stall length in cycles; 0 is treated as 1
is_branch_fault  in  1  branch mispredict resolved this cycle
pc_out  in  WIDTH  current PC
is_load_PC  out  1  PC register load enable
stage_load  out  NUM_STAGES  pipeline register load enable per stage
nop_step  out  NUM_STAGES  bubble inject per stage; bit 0 is always 0
stage_valid  out  NUM_STAGES  registered per-stage valid bits
halted  out  1  program finished and pipeline empty

Behaviour:
State and outputs
- Registered FSM with states RUN, STALL, FLUSH, DRAIN, HALT.
- Outputs are combinational from (state, inputs); stage_valid is registered.
- Input priority: reset > is_branch_fault > is_hazard > end-of-program.

Reset
- While reset=1, outputs are forced to: is_load_PC=0, stage_load=0, nop_step=all-ones except bit 0, halted=0.
- On the next edge: state=RUN, stage_valid=0, stall counter=0, flush counter=0.
- Reset applied mid-STALL/FLUSH/DRAIN aborts the operation with no residue.

RUN, no events
- is_load_PC = (pc_out < INSTRACTION_NUMBERS).
- stage_load = all-ones, nop_step = 0.
- stage_valid shifts up one position; bit0 <= is_load_PC.

RUN with is_hazard (no fault)
- Stall response in the same cycle:
  - is_load_PC=0.
  - stage_load[i]=0 for i < HAZARD_STAGE.
  - nop_step[HAZARD_STAGE]=1.
  - Stages above HAZARD_STAGE advance.
  - stage_valid[HAZARD_STAGE] <= 0.
- Let L = max(hazard_len, 1). If L > 1, go to STALL with counter=L-1.
- Total stall cycles = L, including the detection cycle.

STALL
- Same outputs as the hazard cycle. is_hazard is ignored.
- Counter decrements each cycle; exit to RUN in the cycle the counter reaches 1.

is_branch_fault (any state except HALT)
- Same-cycle response:
  - is_load_PC=1 (redirect target supplied externally).
  - stage_load=all-ones.
  - nop_step[1..FLUSH_DEPTH]=1.
  - stage_valid[1..FLUSH_DEPTH] <= 0.
- Any stall counter is cleared.
- Next state: FLUSH if BRANCH_PENALTY > 0, else RUN.

FLUSH
- nop_step[1]=1, stage_valid[1] <= 0; other stages advance.
- is_load_PC=1 gated by the end-of-program check.
- Lasts BRANCH_PENALTY cycles, then RUN.

End of program
- pc_out >= INSTRACTION_NUMBERS in RUN → DRAIN, with is_load_PC=0.
- DRAIN: stages advance, bit0 valid <= 0. When stage_valid becomes all-zero → HALT.
- Branch fault in DRAIN → fault handling as above.

HALT
- Sticky until reset. halted=1, is_load_PC=0, stage_load=0, nop_step=0.
- Hazard and fault inputs are ignored.

Simultaneous events
- Fault + hazard in the same cycle: fault wins, no stall.
- Hazard with pc_out at the end: stall first, then DRAIN.

Optional Feature:
PIPE_PERF_CNT_EN
- Defined: adds outputs stall_cycles (32) and flush_cycles (32).
  - Saturating counters of cycles in which any nop_step bit was set due to a hazard or due to a fault respectively.
  - Cleared by reset; frozen in HALT.
- Undefined: ports and logic are absent; the rest of the behaviour is identical.

Decomposition:
- Package pipe_ctrl_pkg holds:
  - the FSM state enum (RUN, STALL, FLUSH, DRAIN, HALT);
  - the default constants for NUM_STAGES, HAZARD_STAGE and FLUSH_DEPTH;
  - a function building the flush mask from FLUSH_DEPTH.
- One sub-module, pipe_valid_tracker: the stage_valid shift register with per-stage hold/clear masks.

Test Plan:
1. Reset then run, pc_out 0..15 → is_load_PC=1 each cycle; stage_valid fills 00001, 00011, … 11111 over 5 cycles; nop_step=0.
2. is_hazard with hazard_len=3 at pc_out=4 → exactly 3 cycles with is_load_PC=0, stage_load[1:0]=0, nop_step[2]=1; resumes on the 4th cycle; stage_valid[2]=0 for 3 consecutive cycles.
3. is_branch_fault while in STALL (counter=2) → same cycle nop_step=01110, is_load_PC=1; next cycle FLUSH with nop_step=00010; RUN after that, no further stall.
4. Fault and hazard asserted together → fault behaviour only; hazard_len is ignored; no STALL entry.
5. pc_out reaches 16 → is_load_PC=0, DRAIN for 5 cycles until stage_valid=0, then halted=1; later fault/hazard pulses produce no output change.
6. Reset asserted in the 2nd cycle of a 4-cycle stall → next cycle state=RUN, stage_valid=0; with PIPE_PERF_CNT_EN, stall_cycles=0.
